// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock-divide controller.
package clk_div_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    // Smallest usable divide ratio; anything below is rejected with cfg_err.
    localparam int MIN_DIV = 2;

    // Length of the high phase for ratio n; odd ratios get the longer phase high.
    // Returned 32 bits wide so that n = 2**CNT_W-1 does not wrap.
    function automatic int unsigned half_hi(input int unsigned n);
        return (n + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_period_cnt.sv
// Loadable modulo-N period counter. Exposes the count for the next cycle
// (so the owner can register outputs that line up with the count) and a
// wrap flag that is high while the current count is N-1.
module clk_div_period_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CNT_W-1:0] div,
    output logic [CNT_W-1:0] cnt_next,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: held at zero while cleared, otherwise counts 0..div-1 and wraps.
    always_comb begin
        wrap  = (cnt_q == div - CNT_W'(1));
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || wrap) begin
            cnt_d = '0;
        end
        cnt_next = cnt_d;
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock-divide controller: config handshake, STOP/RUN/PEND
// sequencing so ratio changes land only on a period boundary, and the
// registered divided clock, clock-enable, busy and error outputs.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_en,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_err,
    output logic             clk_o,
    output logic             clk_en_o,
    output logic             busy,
    output logic [CNT_W-1:0] active_div
);

    state_e           state_q,      state_d;
    logic [CNT_W-1:0] active_div_q, active_div_d;
    logic [CNT_W-1:0] pend_div_q,   pend_div_d;
    logic             pend_en_q,    pend_en_d;
    logic             busy_q,       busy_d;
    logic             clk_o_q,      clk_o_d;
    logic             clk_en_q,     clk_en_d;
    logic             cfg_err_q,    cfg_err_d;

    logic             accept;
    logic             bad_div;
    logic [CNT_W-1:0] cnt_next;
    logic             wrap;

    // The counter is parked at zero whenever the block is stopped.
    clk_div_period_cnt #(
        .CNT_W (CNT_W)
    ) u_period_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q == STOP),
        .div      (active_div_q),
        .cnt_next (cnt_next),
        .wrap     (wrap)
    );

    assign cfg_ready  = (state_q != PEND);
    assign cfg_err    = cfg_err_q;
    assign clk_o      = clk_o_q;
    assign clk_en_o   = clk_en_q;
    assign busy       = busy_q;
    assign active_div = active_div_q;

    // Next-state logic: handshake, pending-change sequencing and output values
    // computed from the count of the coming cycle so the registered outputs line up with it.
    always_comb begin
        accept       = cfg_valid && cfg_ready;
        bad_div      = (cfg_div < CNT_W'(MIN_DIV));
        state_d      = state_q;
        active_div_d = active_div_q;
        pend_div_d   = pend_div_q;
        pend_en_d    = pend_en_q;
        cfg_err_d    = accept && bad_div;

        case (state_q)
            STOP: begin
                if (accept && !bad_div) begin
                    active_div_d = cfg_div;
                    if (cfg_en) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (accept && !bad_div) begin
                    pend_en_d  = cfg_en;
                    pend_div_d = cfg_div;
                    state_d    = PEND;
                end
            end
            PEND: begin
                if (wrap) begin
                    active_div_d = pend_div_q;
                    state_d      = pend_en_q ? RUN : STOP;
                end
            end
            default: begin
                state_d = STOP;
            end
        endcase

        busy_d   = (state_d == PEND);
        clk_o_d  = (state_d != STOP) && (32'(cnt_next) < half_hi(32'(active_div_d)));
        clk_en_d = (state_d != STOP) && (cnt_next == active_div_d - CNT_W'(1));
    end

    // Single state/output register bank with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= STOP;
            active_div_q <= CNT_W'(DEFAULT_DIV);
            pend_div_q   <= CNT_W'(DEFAULT_DIV);
            pend_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            clk_o_q      <= 1'b0;
            clk_en_q     <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_div_q <= active_div_d;
            pend_div_q   <= pend_div_d;
            pend_en_q    <= pend_en_d;
            busy_q       <= busy_d;
            clk_o_q      <= clk_o_d;
            clk_en_q     <= clk_en_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Testbench for clk_div_ctrl. Each scenario queues per-cycle stimulus together
// with the expected outputs for that cycle, then replays the queue, comparing
// the DUT at the falling edge after each rising edge.
module tb_clk_div_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_en;
    logic [7:0] cfg_div;
    logic       cfg_err;
    logic       clk_o;
    logic       clk_en_o;
    logic       busy;
    logic [7:0] active_div;

    typedef struct packed {
        logic       r;
        logic       v;
        logic       en;
        logic [7:0] div;
    } stim_t;

    typedef struct packed {
        logic       co;
        logic       ce;
        logic       bz;
        logic       rdy;
        logic       er;
        logic [7:0] ad;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fails  = 0;

    clk_div_ctrl #(
        .CNT_W       (8),
        .DEFAULT_DIV (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_en     (cfg_en),
        .cfg_div    (cfg_div),
        .cfg_err    (cfg_err),
        .clk_o      (clk_o),
        .clk_en_o   (clk_en_o),
        .busy       (busy),
        .active_div (active_div)
    );

    // Free-running system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Queue one cycle of stimulus and the outputs expected after the following rising edge.
    function automatic void push(input logic r, input logic v, input logic en, input logic [7:0] d,
                                 input logic co, input logic ce, input logic bz, input logic rdy,
                                 input logic er, input logic [7:0] ad);
        stim_t s;
        exp_t  e;
        s = '{r: r, v: v, en: en, div: d};
        e = '{co: co, ce: ce, bz: bz, rdy: rdy, er: er, ad: ad};
        stim_q.push_back(s);
        exp_q.push_back(e);
    endfunction

    // Queue idle cycles of a running period of ratio n starting at phase k0.
    function automatic void push_run(input int n, input int k0, input int cycles,
                                     input logic bz, input logic rdy, input logic [7:0] ad);
        for (int i = 0; i < cycles; i++) begin
            int k;
            k = (k0 + i) % n;
            push(1'b0, 1'b0, 1'b0, 8'd0, (k < (n + 1) / 2), (k == n - 1), bz, rdy, 1'b0, ad);
        end
    endfunction

    // Queue idle cycles in STOP with the given ratio in effect.
    function automatic void push_stop(input int cycles, input logic [7:0] ad);
        for (int i = 0; i < cycles; i++) begin
            push(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ad);
        end
    endfunction

    // Queue a reset cycle, which must show all reset values.
    function automatic void push_reset();
        push(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
    endfunction

    task automatic test_reset();
        stim_t s;
        exp_t  e;
        exp_t  o;
        int    cyc;
        push(1'b1, 1'b1, 1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
        push_reset();
        push_stop(3, 8'd4);
        cyc = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst = s.r; cfg_valid = s.v; cfg_en = s.en; cfg_div = s.div;
            @(negedge clk);
            e = exp_q.pop_front();
            o = '{co: clk_o, ce: clk_en_o, bz: busy, rdy: cfg_ready, er: cfg_err, ad: active_div};
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("[TB] FAIL reset cycle %0d: got co/ce/bz/rdy/er/ad=%b%b%b%b%b/%0d expected %b%b%b%b%b/%0d",
                         cyc, o.co, o.ce, o.bz, o.rdy, o.er, o.ad, e.co, e.ce, e.bz, e.rdy, e.er, e.ad);
            end
            cyc++;
        end
    endtask

    task automatic test_basic();
        stim_t s;
        exp_t  e;
        exp_t  o;
        int    cyc;
        push_reset();
        push(1'b0, 1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
        push_run(4, 1, 11, 1'b0, 1'b1, 8'd4);
        // Same ratio again: still sequenced through PEND, waveform unchanged.
        push(1'b0, 1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4);
        push_run(4, 1, 3, 1'b1, 1'b0, 8'd4);
        push_run(4, 0, 8, 1'b0, 1'b1, 8'd4);
        cyc = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst = s.r; cfg_valid = s.v; cfg_en = s.en; cfg_div = s.div;
            @(negedge clk);
            e = exp_q.pop_front();
            o = '{co: clk_o, ce: clk_en_o, bz: busy, rdy: cfg_ready, er: cfg_err, ad: active_div};
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("[TB] FAIL basic cycle %0d: got co/ce/bz/rdy/er/ad=%b%b%b%b%b/%0d expected %b%b%b%b%b/%0d",
                         cyc, o.co, o.ce, o.bz, o.rdy, o.er, o.ad, e.co, e.ce, e.bz, e.rdy, e.er, e.ad);
            end
            cyc++;
        end
    endtask

    task automatic test_change();
        stim_t s;
        exp_t  e;
        exp_t  o;
        int    cyc;
        push_reset();
        push(1'b0, 1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
        push_run(4, 1, 1, 1'b0, 1'b1, 8'd4);
        // Mid-period request for div=6; old period finishes first.
        push(1'b0, 1'b1, 1'b1, 8'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4);
        push_run(4, 3, 1, 1'b1, 1'b0, 8'd4);
        push_run(6, 0, 12, 1'b0, 1'b1, 8'd6);
        // Request presented while cnt == N-1: applies a full period later.
        push(1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd6);
        push_run(6, 1, 5, 1'b1, 1'b0, 8'd6);
        push_run(3, 0, 6, 1'b0, 1'b1, 8'd3);
        cyc = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst = s.r; cfg_valid = s.v; cfg_en = s.en; cfg_div = s.div;
            @(negedge clk);
            e = exp_q.pop_front();
            o = '{co: clk_o, ce: clk_en_o, bz: busy, rdy: cfg_ready, er: cfg_err, ad: active_div};
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("[TB] FAIL change cycle %0d: got co/ce/bz/rdy/er/ad=%b%b%b%b%b/%0d expected %b%b%b%b%b/%0d",
                         cyc, o.co, o.ce, o.bz, o.rdy, o.er, o.ad, e.co, e.ce, e.bz, e.rdy, e.er, e.ad);
            end
            cyc++;
        end
    endtask

    task automatic test_err();
        stim_t s;
        exp_t  e;
        exp_t  o;
        int    cyc;
        push_reset();
        // div=1 in STOP: error pulse only.
        push(1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd4);
        push_stop(2, 8'd4);
        push(1'b0, 1'b1, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
        push_run(5, 1, 2, 1'b0, 1'b1, 8'd5);
        // div=0 in RUN: error pulse, waveform and ratio untouched.
        push(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd5);
        push_run(5, 4, 7, 1'b0, 1'b1, 8'd5);
        cyc = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst = s.r; cfg_valid = s.v; cfg_en = s.en; cfg_div = s.div;
            @(negedge clk);
            e = exp_q.pop_front();
            o = '{co: clk_o, ce: clk_en_o, bz: busy, rdy: cfg_ready, er: cfg_err, ad: active_div};
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("[TB] FAIL err cycle %0d: got co/ce/bz/rdy/er/ad=%b%b%b%b%b/%0d expected %b%b%b%b%b/%0d",
                         cyc, o.co, o.ce, o.bz, o.rdy, o.er, o.ad, e.co, e.ce, e.bz, e.rdy, e.er, e.ad);
            end
            cyc++;
        end
    endtask

    task automatic test_stop();
        stim_t s;
        exp_t  e;
        exp_t  o;
        int    cyc;
        push_reset();
        push(1'b0, 1'b1, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
        push_run(5, 1, 1, 1'b0, 1'b1, 8'd5);
        push(1'b0, 1'b1, 1'b0, 8'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5);
        push_run(5, 3, 2, 1'b1, 1'b0, 8'd5);
        push_stop(6, 8'd5);
        cyc = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst = s.r; cfg_valid = s.v; cfg_en = s.en; cfg_div = s.div;
            @(negedge clk);
            e = exp_q.pop_front();
            o = '{co: clk_o, ce: clk_en_o, bz: busy, rdy: cfg_ready, er: cfg_err, ad: active_div};
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("[TB] FAIL stop cycle %0d: got co/ce/bz/rdy/er/ad=%b%b%b%b%b/%0d expected %b%b%b%b%b/%0d",
                         cyc, o.co, o.ce, o.bz, o.rdy, o.er, o.ad, e.co, e.ce, e.bz, e.rdy, e.er, e.ad);
            end
            cyc++;
        end
    endtask

    task automatic test_extremes();
        stim_t s;
        exp_t  e;
        exp_t  o;
        int    cyc;
        push_reset();
        push(1'b0, 1'b1, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
        push_run(2, 1, 7, 1'b0, 1'b1, 8'd2);
        push_reset();
        push(1'b0, 1'b1, 1'b1, 8'd255, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd255);
        push_run(255, 1, 3 * 255 + 3, 1'b0, 1'b1, 8'd255);
        cyc = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst = s.r; cfg_valid = s.v; cfg_en = s.en; cfg_div = s.div;
            @(negedge clk);
            e = exp_q.pop_front();
            o = '{co: clk_o, ce: clk_en_o, bz: busy, rdy: cfg_ready, er: cfg_err, ad: active_div};
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("[TB] FAIL extremes cycle %0d: got co/ce/bz/rdy/er/ad=%b%b%b%b%b/%0d expected %b%b%b%b%b/%0d",
                         cyc, o.co, o.ce, o.bz, o.rdy, o.er, o.ad, e.co, e.ce, e.bz, e.rdy, e.er, e.ad);
            end
            cyc++;
        end
    endtask

    task automatic test_reset_pend();
        stim_t s;
        exp_t  e;
        exp_t  o;
        int    cyc;
        push_reset();
        push(1'b0, 1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
        push(1'b0, 1'b1, 1'b1, 8'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4);
        push_run(4, 2, 1, 1'b1, 1'b0, 8'd4);
        push_reset();
        push_stop(8, 8'd4);
        cyc = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst = s.r; cfg_valid = s.v; cfg_en = s.en; cfg_div = s.div;
            @(negedge clk);
            e = exp_q.pop_front();
            o = '{co: clk_o, ce: clk_en_o, bz: busy, rdy: cfg_ready, er: cfg_err, ad: active_div};
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("[TB] FAIL reset_pend cycle %0d: got co/ce/bz/rdy/er/ad=%b%b%b%b%b/%0d expected %b%b%b%b%b/%0d",
                         cyc, o.co, o.ce, o.bz, o.rdy, o.er, o.ad, e.co, e.ce, e.bz, e.rdy, e.er, e.ad);
            end
            cyc++;
        end
    endtask

    // Scenario sequence; every scenario starts and ends on a falling edge.
    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_en    = 1'b0;
        cfg_div   = 8'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_change();
        test_err();
        test_stop();
        test_extremes();
        test_reset_pend();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
